// File: rtl/heu_window_tx.sv
// HEU window transmitter: packs a serial pixel stream into LANES x DEPTH windows,
// ping-pong buffered, and hands each full window to the HEU with a one-cycle strobe.
module heu_window_tx #(
   parameter int unsigned PIX_W = 8,
   parameter int unsigned LANES = 5,
   parameter int unsigned DEPTH = 80
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pix_valid,
   output logic             pix_ready,
   input  logic [PIX_W-1:0] pix,
   input  logic             pix_sof,
   input  logic             heu_in_ready,
   output logic             out_ready,
   output logic [PIX_W-1:0] d [LANES-1:0][DEPTH-1:0],
   output logic [15:0]      win_sent,
   output logic             sof_drop
);

   localparam int unsigned KW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned JW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [0:0] {StIdle, StStrobe} state_e;

   state_e          state_q, state_d;
   logic [1:0]      full_q, full_d;
   logic            fill_sel_q, fill_sel_d;
   logic            send_sel_q, send_sel_d;
   logic [KW-1:0]   fill_k_q, fill_k_d;
   logic [JW-1:0]   fill_j_q, fill_j_d;
   logic [15:0]     win_sent_q, win_sent_d;
   logic            sof_drop_q, sof_drop_d;

   logic            accept;
   logic            fill_busy;
   logic            pos_last;
   logic [KW-1:0]   pos_k;
   logic [JW-1:0]   pos_j;

   logic [PIX_W-1:0] mem [2][LANES][DEPTH];

   assign pix_ready = !rst && !full_q[fill_sel_q];
   assign accept    = pix_valid && pix_ready;
   assign fill_busy = (fill_k_q != '0) || (fill_j_q != '0);

   // A sof beat always lands at position 0, discarding whatever partial window preceded it.
   assign pos_k    = pix_sof ? '0 : fill_k_q;
   assign pos_j    = pix_sof ? '0 : fill_j_q;
   assign pos_last = (pos_k == KW'(LANES - 1)) && (pos_j == JW'(DEPTH - 1));

   always_ff @(posedge clk) begin
      if (accept) begin
         mem[fill_sel_q][pos_k][pos_j] <= pix;
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      for (genvar j = 0; j < DEPTH; j++) begin : g_col
         assign d[k][j] = mem[send_sel_q][k][j];
      end
   end

   always_comb begin
      fill_k_d   = fill_k_q;
      fill_j_d   = fill_j_q;
      fill_sel_d = fill_sel_q;
      full_d     = full_q;
      sof_drop_d = 1'b0;
      if (accept) begin
         sof_drop_d = pix_sof && fill_busy;
         if (pos_last) begin
            full_d[fill_sel_q] = 1'b1;
            fill_sel_d         = ~fill_sel_q;
            fill_k_d           = '0;
            fill_j_d           = '0;
         end else if (pos_k == KW'(LANES - 1)) begin
            fill_k_d = '0;
            fill_j_d = pos_j + 1'b1;
         end else begin
            fill_k_d = pos_k + 1'b1;
            fill_j_d = pos_j;
         end
      end
      // The buffer being sent is always full, so it never collides with the one being filled.
      if (state_q == StStrobe) begin
         full_d[send_sel_q] = 1'b0;
      end
   end

   always_comb begin
      state_d    = state_q;
      send_sel_d = send_sel_q;
      win_sent_d = win_sent_q;
      unique case (state_q)
         StIdle: begin
            if (full_q[send_sel_q] && heu_in_ready) begin
               state_d = StStrobe;
            end
         end
         StStrobe: begin
            state_d    = StIdle;
            send_sel_d = ~send_sel_q;
            win_sent_d = win_sent_q + 16'd1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         full_q     <= '0;
         fill_sel_q <= 1'b0;
         send_sel_q <= 1'b0;
         fill_k_q   <= '0;
         fill_j_q   <= '0;
         win_sent_q <= '0;
         sof_drop_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         full_q     <= full_d;
         fill_sel_q <= fill_sel_d;
         send_sel_q <= send_sel_d;
         fill_k_q   <= fill_k_d;
         fill_j_q   <= fill_j_d;
         win_sent_q <= win_sent_d;
         sof_drop_q <= sof_drop_d;
      end
   end

   assign out_ready = (state_q == StStrobe) && !rst;
   assign win_sent  = win_sent_q;
   assign sof_drop  = sof_drop_q;

endmodule

// File: tb/tb_heu_window_tx.sv
// Directed bench for heu_window_tx: window fill order, ping-pong handoff, sof drop,
// reset recovery and a randomised 50-window scoreboard run.
module tb_heu_window_tx;

   typedef logic [7:0] win_t [400];

   logic       clk = 1'b0;
   logic       rst;
   logic       pix_valid;
   logic       pix_ready;
   logic [7:0] pix;
   logic       pix_sof;
   logic       heu_in_ready;
   logic       out_ready;
   logic [7:0] d [4:0][79:0];
   logic [15:0] win_sent;
   logic       sof_drop;

   int n_cmp = 0;
   int n_err = 0;
   int stall_cnt = 0;

   win_t cap_q[$];
   win_t cap_w;
   int   b2b_cnt = 0;
   int   sof_drop_cnt = 0;
   logic prev_or = 1'b0;

   heu_window_tx #(.PIX_W(8), .LANES(5), .DEPTH(80)) dut (
      .clk          (clk),
      .rst          (rst),
      .pix_valid    (pix_valid),
      .pix_ready    (pix_ready),
      .pix          (pix),
      .pix_sof      (pix_sof),
      .heu_in_ready (heu_in_ready),
      .out_ready    (out_ready),
      .d            (d),
      .win_sent     (win_sent),
      .sof_drop     (sof_drop)
   );

   always #5 clk = ~clk;

   // Capture each strobed window in beat order (n = 5j + k).
   always @(negedge clk) begin
      if (out_ready === 1'b1) begin
         for (int j = 0; j < 80; j++)
            for (int k = 0; k < 5; k++)
               cap_w[j*5+k] = d[k][j];
         cap_q.push_back(cap_w);
         if (prev_or === 1'b1) b2b_cnt++;
      end
      prev_or = out_ready;
      if (sof_drop === 1'b1) sof_drop_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one beat until accepted; returns one cycle after the accepting edge.
   task automatic send_beat(input logic [7:0] p, input logic sof, input bit rnd_heu);
      bit ok = 0;
      pix = p;
      pix_sof = sof;
      pix_valid = 1'b1;
      for (int t = 0; t < 2000 && !ok; t++) begin
         if (rnd_heu) heu_in_ready = 1'($urandom_range(0, 1));
         if (pix_ready === 1'b1) ok = 1;
         step();
      end
      pix_valid = 1'b0;
      pix_sof = 1'b0;
      if (!ok) stall_cnt++;
   endtask

   task automatic stream_window(input win_t w);
      for (int n = 0; n < 400; n++) send_beat(w[n], n == 0, 1'b0);
   endtask

   task automatic wait_caps(input int target);
      for (int t = 0; t < 3000 && cap_q.size() < target; t++) step();
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      pix_valid = 1'b0;
      pix_sof = 1'b0;
      pix = '0;
      heu_in_ready = 1'b0;
      rst = 1'b1;
      step();
      n_cmp++;
      if (pix_ready !== 1'b0) begin
         n_err++;
         $display("FAIL reset_pix_ready: got %b, required 0", pix_ready);
      end
      step();
      rst = 1'b0;
      #1;
      n_cmp++;
      if (out_ready !== 1'b0 || win_sent !== 16'd0 || sof_drop !== 1'b0) begin
         n_err++;
         $display("FAIL reset_outputs: got out_ready=%b win_sent=%0d sof_drop=%b, required 0/0/0",
                  out_ready, win_sent, sof_drop);
      end
      n_cmp++;
      if (pix_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_release_ready: got %b, required 1", pix_ready);
      end
   endtask

   task automatic test_single_window();
      win_t e;
      int base = cap_q.size();
      int nbad = 0;
      for (int n = 0; n < 400; n++) e[n] = 8'(n % 256);
      heu_in_ready = 1'b1;
      stream_window(e);
      n_cmp++;
      if (out_ready !== 1'b0) begin
         n_err++;
         $display("FAIL t1_latency_early: out_ready got %b at T+1, required 0", out_ready);
      end
      step();
      n_cmp++;
      if (out_ready !== 1'b1) begin
         n_err++;
         $display("FAIL t1_latency_strobe: out_ready got %b at T+2, required 1", out_ready);
      end
      step();
      n_cmp++;
      if (out_ready !== 1'b0 || win_sent !== 16'd1) begin
         n_err++;
         $display("FAIL t1_after_strobe: got out_ready=%b win_sent=%0d, required 0/1",
                  out_ready, win_sent);
      end
      step();
      step();
      n_cmp++;
      if (cap_q.size() - base !== 1) begin
         n_err++;
         $display("FAIL t1_pulse_count: got %0d strobes, required 1", cap_q.size() - base);
      end else begin
         for (int n = 0; n < 400; n++) if (cap_q[base][n] !== e[n]) nbad++;
         n_cmp++;
         if (nbad != 0) begin
            n_err++;
            $display("FAIL t1_window: got %0d bad pixels, required 0", nbad);
         end
      end
   endtask

   task automatic test_ping_pong();
      win_t a, b;
      int base;
      int nbad;
      for (int n = 0; n < 400; n++) begin
         a[n] = 8'((n * 7 + 3) % 256);
         b[n] = 8'((n * 13 + 200) % 256);
      end
      heu_in_ready = 1'b0;
      base = cap_q.size();
      stream_window(a);
      stream_window(b);
      n_cmp++;
      if (pix_ready !== 1'b0) begin
         n_err++;
         $display("FAIL t2_both_full_ready: got %b, required 0", pix_ready);
      end
      for (int i = 0; i < 5; i++) step();
      n_cmp++;
      if (cap_q.size() != base || pix_ready !== 1'b0) begin
         n_err++;
         $display("FAIL t2_hold: got %0d strobes pix_ready=%b, required 0 strobes and 0",
                  cap_q.size() - base, pix_ready);
      end
      heu_in_ready = 1'b1;
      step();
      n_cmp++;
      if (out_ready !== 1'b1 || pix_ready !== 1'b0) begin
         n_err++;
         $display("FAIL t2_strobe_a: got out_ready=%b pix_ready=%b, required 1/0",
                  out_ready, pix_ready);
      end
      step();
      n_cmp++;
      if (out_ready !== 1'b0 || pix_ready !== 1'b1) begin
         n_err++;
         $display("FAIL t2_gap: got out_ready=%b pix_ready=%b, required 0/1", out_ready, pix_ready);
      end
      step();
      n_cmp++;
      if (out_ready !== 1'b1) begin
         n_err++;
         $display("FAIL t2_strobe_b: got out_ready=%b, required 1", out_ready);
      end
      step();
      n_cmp++;
      if (out_ready !== 1'b0 || win_sent !== 16'd3) begin
         n_err++;
         $display("FAIL t2_done: got out_ready=%b win_sent=%0d, required 0/3", out_ready, win_sent);
      end
      n_cmp++;
      if (cap_q.size() - base !== 2) begin
         n_err++;
         $display("FAIL t2_count: got %0d strobes, required 2", cap_q.size() - base);
      end else begin
         nbad = 0;
         for (int n = 0; n < 400; n++) begin
            if (cap_q[base][n] !== a[n]) nbad++;
            if (cap_q[base+1][n] !== b[n]) nbad++;
         end
         n_cmp++;
         if (nbad != 0) begin
            n_err++;
            $display("FAIL t2_windows_ab: got %0d bad pixels, required 0", nbad);
         end
      end
   endtask

   task automatic test_sof_drop();
      win_t e;
      int base = cap_q.size();
      int drops0 = sof_drop_cnt;
      int nbad = 0;
      heu_in_ready = 1'b1;
      for (int n = 0; n < 137; n++) send_beat(8'(n + 50), n == 0, 1'b0);
      e[0] = 8'hA5;
      for (int n = 1; n < 400; n++) e[n] = 8'((n * 11) % 256);
      send_beat(e[0], 1'b1, 1'b0);
      n_cmp++;
      if (sof_drop !== 1'b1) begin
         n_err++;
         $display("FAIL t3_sof_drop_pulse: got %b, required 1", sof_drop);
      end
      send_beat(e[1], 1'b0, 1'b0);
      n_cmp++;
      if (sof_drop !== 1'b0) begin
         n_err++;
         $display("FAIL t3_sof_drop_clear: got %b, required 0", sof_drop);
      end
      for (int n = 2; n < 400; n++) send_beat(e[n], 1'b0, 1'b0);
      wait_caps(base + 1);
      step();
      step();
      n_cmp++;
      if (sof_drop_cnt - drops0 !== 1 || win_sent !== 16'd4) begin
         n_err++;
         $display("FAIL t3_counts: got drops=%0d win_sent=%0d, required 1/4",
                  sof_drop_cnt - drops0, win_sent);
      end
      n_cmp++;
      if (cap_q.size() - base !== 1) begin
         n_err++;
         $display("FAIL t3_strobe_count: got %0d, required 1", cap_q.size() - base);
      end else begin
         n_cmp++;
         if (cap_q[base][0] !== 8'hA5) begin
            n_err++;
            $display("FAIL t3_d00: got %h, required a5", cap_q[base][0]);
         end
         for (int n = 0; n < 400; n++) if (cap_q[base][n] !== e[n]) nbad++;
         n_cmp++;
         if (nbad != 0) begin
            n_err++;
            $display("FAIL t3_window: got %0d bad pixels, required 0", nbad);
         end
      end
   endtask

   task automatic test_reset_recovery();
      win_t e;
      int base;
      int nbad;
      for (int n = 0; n < 400; n++) e[n] = 8'((n * 29 + 1) % 256);
      heu_in_ready = 1'b1;
      // Reset mid-fill.
      for (int n = 0; n < 251; n++) send_beat(8'(n), n == 0, 1'b0);
      rst = 1'b1;
      #1;
      n_cmp++;
      if (pix_ready !== 1'b0 || out_ready !== 1'b0) begin
         n_err++;
         $display("FAIL t4_fill_rst_outputs: got pix_ready=%b out_ready=%b, required 0/0",
                  pix_ready, out_ready);
      end
      step();
      n_cmp++;
      if (win_sent !== 16'd0) begin
         n_err++;
         $display("FAIL t4_fill_rst_count: got win_sent=%0d, required 0", win_sent);
      end
      rst = 1'b0;
      base = cap_q.size();
      stream_window(e);
      wait_caps(base + 1);
      step();
      nbad = 0;
      if (cap_q.size() > base) for (int n = 0; n < 400; n++) if (cap_q[base][n] !== e[n]) nbad++;
      n_cmp++;
      if (cap_q.size() - base !== 1 || nbad != 0 || win_sent !== 16'd1) begin
         n_err++;
         $display("FAIL t4_fill_recover: got strobes=%0d bad=%0d win_sent=%0d, required 1/0/1",
                  cap_q.size() - base, nbad, win_sent);
      end
      // Reset during the strobe cycle.
      stream_window(e);
      step();
      n_cmp++;
      if (out_ready !== 1'b1) begin
         n_err++;
         $display("FAIL t4_pre_strobe: got out_ready=%b, required 1", out_ready);
      end
      base = cap_q.size();
      rst = 1'b1;
      #1;
      n_cmp++;
      if (pix_ready !== 1'b0 || out_ready !== 1'b0) begin
         n_err++;
         $display("FAIL t4_strobe_rst_outputs: got pix_ready=%b out_ready=%b, required 0/0",
                  pix_ready, out_ready);
      end
      step();
      rst = 1'b0;
      step();
      step();
      n_cmp++;
      if (out_ready !== 1'b0 || win_sent !== 16'd0 || cap_q.size() != base) begin
         n_err++;
         $display("FAIL t4_strobe_abort: got out_ready=%b win_sent=%0d strobes=%0d, required 0/0/0",
                  out_ready, win_sent, cap_q.size() - base);
      end
      stream_window(e);
      wait_caps(base + 1);
      step();
      nbad = 0;
      if (cap_q.size() > base) for (int n = 0; n < 400; n++) if (cap_q[base][n] !== e[n]) nbad++;
      n_cmp++;
      if (cap_q.size() - base !== 1 || nbad != 0 || win_sent !== 16'd1) begin
         n_err++;
         $display("FAIL t4_strobe_recover: got strobes=%0d bad=%0d win_sent=%0d, required 1/0/1",
                  cap_q.size() - base, nbad, win_sent);
      end
   endtask

   task automatic test_random_stream();
      win_t exp_q[$];
      win_t w;
      int base;
      int nbad;
      int b2b0;
      pulse_reset();
      base = cap_q.size();
      b2b0 = b2b_cnt;
      for (int win = 0; win < 50; win++) begin
         for (int n = 0; n < 400; n++) w[n] = 8'($urandom);
         exp_q.push_back(w);
         for (int n = 0; n < 400; n++) begin
            while ($urandom_range(0, 3) == 0) begin
               heu_in_ready = 1'($urandom_range(0, 1));
               step();
            end
            send_beat(w[n], n == 0, 1'b1);
         end
      end
      heu_in_ready = 1'b1;
      wait_caps(base + 50);
      for (int i = 0; i < 6; i++) step();
      n_cmp++;
      if (cap_q.size() - base !== 50 || win_sent !== 16'd50) begin
         n_err++;
         $display("FAIL t5_counts: got strobes=%0d win_sent=%0d, required 50/50",
                  cap_q.size() - base, win_sent);
      end
      n_cmp++;
      if (b2b_cnt - b2b0 !== 0) begin
         n_err++;
         $display("FAIL t5_back_to_back: got %0d adjacent strobes, required 0", b2b_cnt - b2b0);
      end
      for (int win = 0; win < 50 && base + win < cap_q.size(); win++) begin
         nbad = 0;
         for (int n = 0; n < 400; n++) if (cap_q[base+win][n] !== exp_q[win][n]) nbad++;
         n_cmp++;
         if (nbad != 0) begin
            n_err++;
            $display("FAIL t5_window_%0d: got %0d bad pixels, required 0", win, nbad);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_window();
      test_ping_pong();
      test_sof_drop();
      test_reset_recovery();
      test_random_stream();
      n_cmp++;
      if (stall_cnt !== 0) begin
         n_err++;
         $display("FAIL beat_timeouts: got %0d stalled beats, required 0", stall_cnt);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
